// File: rtl/countdown_ctrl_mod.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_ctrl_mod
//  Purpose  : Countdown sequencer for the bomb timer: arm/start via config
//             button, tick divider, borrow requests, expiry and defuse flags.
//  Revision : 1.0  initial release
// ============================================================================
module countdown_ctrl_mod #(
    parameter int unsigned TICK_DIV = 32'd50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       configBtn,
    input  logic       defuse,
    input  logic [3:0] lowDigit,
    input  logic       lowNoBorrow,
    output logic       timerReconfig,
    output logic       borrowDown,
    output logic       running,
    output logic       expired,
    output logic       defused,
    output logic [2:0] state
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOADED  = 3'd1;
    localparam logic [2:0] c_ST_RUNNING = 3'd2;
    localparam logic [2:0] c_ST_EXPIRED = 3'd3;
    localparam logic [2:0] c_ST_DEFUSED = 3'd4;

    localparam logic [31:0] c_TICK_LAST = TICK_DIV - 32'd1;

    logic [2:0]  state_q, state_d;
    logic [31:0] tick_q, tick_d;
    logic        btn_q;
    logic        blk_q;
    logic        timerReconfig_q, timerReconfig_d;
    logic        borrowDown_q, borrowDown_d;
    logic        running_q, running_d;
    logic        expired_q, expired_d;
    logic        defused_q, defused_d;

    logic        w_press;
    logic        w_tick;
    logic        w_empty;

    // blk_q masks a button that was already held when reset released
    assign w_press = configBtn & ~btn_q & ~blk_q;
    assign w_tick  = (state_q == c_ST_RUNNING) && (tick_q == c_TICK_LAST);
    assign w_empty = (lowDigit == 4'd0) && lowNoBorrow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_press) state_d = c_ST_LOADED;
            end
            c_ST_LOADED: begin
                if (w_press) state_d = c_ST_RUNNING;
            end
            c_ST_RUNNING: begin
                if (defuse) begin
                    state_d = c_ST_DEFUSED;
                end else if (w_tick && w_empty) begin
                    state_d = c_ST_EXPIRED;
                end
            end
            c_ST_EXPIRED, c_ST_DEFUSED: begin
                if (w_press) state_d = c_ST_LOADED;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        timerReconfig_d = 1'b0;
        borrowDown_d    = 1'b0;
        case (state_q)
            c_ST_RUNNING: borrowDown_d = w_tick & ~defuse & ~w_empty;
            default:      timerReconfig_d = w_press;
        endcase
        running_d = (state_d == c_ST_RUNNING);
        expired_d = (state_d == c_ST_EXPIRED);
        defused_d = (state_d == c_ST_DEFUSED);
    end

    // Tick divider only counts while RUNNING, so it is always 0 on entry
    always_comb begin
        tick_d = 32'd0;
        if ((state_q == c_ST_RUNNING) && (tick_q != c_TICK_LAST)) begin
            tick_d = tick_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q          <= 32'd0;
            btn_q           <= 1'b0;
            blk_q           <= configBtn;
            timerReconfig_q <= 1'b0;
            borrowDown_q    <= 1'b0;
            running_q       <= 1'b0;
            expired_q       <= 1'b0;
            defused_q       <= 1'b0;
        end else begin
            tick_q          <= tick_d;
            btn_q           <= configBtn;
            blk_q           <= blk_q & configBtn;
            timerReconfig_q <= timerReconfig_d;
            borrowDown_q    <= borrowDown_d;
            running_q       <= running_d;
            expired_q       <= expired_d;
            defused_q       <= defused_d;
        end
    end

    assign timerReconfig = timerReconfig_q;
    assign borrowDown    = borrowDown_q;
    assign running       = running_q;
    assign expired       = expired_q;
    assign defused       = defused_q;
    assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_ctrl_mod
//  Purpose  : Self-checking bench for countdown_ctrl_mod (TICK_DIV = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_countdown_ctrl_mod;

    localparam int unsigned TD = 4;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_EXP  = 3'd3;
    localparam logic [2:0] S_DEF  = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       configBtn;
    logic       defuse;
    logic [3:0] lowDigit;
    logic       lowNoBorrow;
    logic       timerReconfig, borrowDown, running, expired, defused;
    logic [2:0] state;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    countdown_ctrl_mod #(.TICK_DIV(TD)) dut (
        .clk          (clk),
        .rst          (rst),
        .configBtn    (configBtn),
        .defuse       (defuse),
        .lowDigit     (lowDigit),
        .lowNoBorrow  (lowNoBorrow),
        .timerReconfig(timerReconfig),
        .borrowDown   (borrowDown),
        .running      (running),
        .expired      (expired),
        .defused      (defused),
        .state        (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: mode plus cycles spent in the current run.
    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] age;
        logic        prev;
        logic        armed;
        logic        tr;
        logic        bd;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_step(input mdl_t cur, input logic r, input logic b,
                                      input logic d, input logic [3:0] ld, input logic lnb);
        mdl_t nx;
        logic press;
        nx    = cur;
        nx.tr = 1'b0;
        nx.bd = 1'b0;
        if (!r) begin
            nx.st    = S_IDLE;
            nx.age   = 32'd0;
            nx.prev  = 1'b0;
            nx.armed = !b;
            return nx;
        end
        press    = b && !cur.prev && cur.armed;
        nx.prev  = b;
        nx.armed = cur.armed || !b;
        if (cur.st == S_RUN) begin
            if (d) begin
                nx.st = S_DEF;
            end else if (((cur.age + 32'd1) % TD) == 32'd0) begin
                if (ld == 4'd0 && lnb) nx.st = S_EXP;
                else                   nx.bd = 1'b1;
            end
            nx.age = cur.age + 32'd1;
        end else if (press) begin
            nx.tr  = 1'b1;
            nx.st  = (cur.st == S_LOAD) ? S_RUN : S_LOAD;
            nx.age = 32'd0;
        end
        return nx;
    endfunction

    always @(posedge clk) m <= mdl_step(m, rst, configBtn, defuse, lowDigit, lowNoBorrow);

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_state",   32'(state),         32'(m.st));
            chk("m_running", 32'(running),       32'(m.st == S_RUN));
            chk("m_expired", 32'(expired),       32'(m.st == S_EXP));
            chk("m_defused", 32'(defused),       32'(m.st == S_DEF));
            chk("m_tr",      32'(timerReconfig), 32'(m.tr));
            chk("m_bd",      32'(borrowDown),    32'(m.bd));
            chk("m_tr_bd_excl", 32'(timerReconfig & borrowDown), 32'd0);
        end
    end

    task automatic press_exp(input logic [2:0] st_after);
        configBtn = 1'b1;
        @(negedge clk);
        chk("press_tr", 32'(timerReconfig), 32'd1);
        chk("press_state", 32'(state), 32'(st_after));
        configBtn = 1'b0;
        @(negedge clk);
        chk("press_tr_one_cycle", 32'(timerReconfig), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bd, first_off, last_off, waited, seen_bd;
        rst = 1'b0; configBtn = 1'b0; defuse = 1'b0;
        lowDigit = 4'd5; lowNoBorrow = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'({timerReconfig, borrowDown, running, expired, defused}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Arm, then start; ends one cycle into RUNNING
        press_exp(S_LOAD);
        press_exp(S_RUN);
        chk("run_flag", 32'(running), 32'd1);

        n_bd = 0; first_off = -1; last_off = -1;
        for (int off = 2; off <= 21; off++) begin
            @(negedge clk);
            if (borrowDown) begin
                n_bd++;
                if (first_off < 0) first_off = off;
                last_off = off;
            end
        end
        chk("bd_count", 32'(n_bd), 32'd5);
        chk("bd_first_offset", 32'(first_off), 32'd4);
        chk("bd_last_offset", 32'(last_off), 32'd20);

        // Expiry: next tick at run age 23, visible at offset 24
        lowDigit = 4'd0; lowNoBorrow = 1'b1;
        waited = 0; seen_bd = 0;
        while (state != S_EXP && waited < 10) begin
            @(negedge clk);
            waited++;
            if (borrowDown) seen_bd++;
        end
        chk("expire_reached", 32'(state), 32'(S_EXP));
        chk("expire_latency", 32'(waited), 32'd3);
        chk("expire_flag", 32'(expired), 32'd1);
        chk("expire_no_bd", 32'(seen_bd), 32'd0);
        seen_bd = 0;
        repeat (6) begin
            @(negedge clk);
            if (borrowDown) seen_bd++;
        end
        chk("expired_no_bd_after", 32'(seen_bd), 32'd0);

        // Re-arm from EXPIRED
        press_exp(S_LOAD);
        chk("rearm_expired_clr", 32'(expired), 32'd0);

        // Defuse coincides with expiry tick at run age 3
        press_exp(S_RUN);
        repeat (2) @(negedge clk);
        defuse = 1'b1;
        @(negedge clk);
        chk("defuse_state", 32'(state), 32'(S_DEF));
        chk("defuse_flag", 32'(defused), 32'd1);
        chk("defuse_not_expired", 32'(expired), 32'd0);
        chk("defuse_no_bd", 32'(borrowDown), 32'd0);
        defuse = 1'b0;

        // Re-arm from DEFUSED; defuse ignored in LOADED
        press_exp(S_LOAD);
        chk("rearm_defused_clr", 32'(defused), 32'd0);
        defuse = 1'b1;
        repeat (2) @(negedge clk);
        chk("defuse_ignored_loaded", 32'(state), 32'(S_LOAD));
        defuse = 1'b0;

        // Reset mid-run with button held
        lowDigit = 4'd5; lowNoBorrow = 1'b0;
        press_exp(S_RUN);
        @(negedge clk);
        configBtn = 1'b1;
        @(negedge clk);
        chk("press_ignored_running", 32'(state), 32'(S_RUN));
        chk("press_ignored_tr", 32'(timerReconfig), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_state", 32'(state), 32'd0);
        chk("midrun_rst_outs", 32'({timerReconfig, borrowDown, running, expired, defused}), 32'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("held_btn_no_press", 32'(state), 32'd0);
            chk("held_btn_no_bd_tr", 32'({timerReconfig, borrowDown}), 32'd0);
        end
        configBtn = 1'b0;
        @(negedge clk);
        press_exp(S_LOAD);
        repeat (3) @(negedge clk);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
